traffic_lamp_monitor: RTL

- Watches the four lamp vectors driven by the intersection controller (T1, T2, S1, S2), decodes them into phases and checks them independently.
- Checks: legal lamp patterns, legal phase order, exact phase dwell times.
- On the first violation it latches a sticky fault and a fault code; only reset or an explicit clear releases it.
- Sits beside the controller as the receive-side safety checker; its fault output feeds the supervisor and lamp-driver fail-safe.

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/traffic_lamp_decoder.sv | 35 +++
 rtl/traffic_lamp_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic lamp monitor.
//   - phase_e      : decoded intersection phase P1..P4 (0..3)
//   - mon_state_e  : monitor FSM state
//   - lamp bit indices, single-lamp vectors, 12-bit phase patterns {T1,T2,S1,S2}
//   - fault codes and default dwell times
package traffic_pkg;

  typedef enum logic [1:0] {P1 = 2'd0, P2 = 2'd1, P3 = 2'd2, P4 = 2'd3} phase_e;

  typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_TRACK = 2'd1, ST_FAULT = 2'd2} mon_state_e;

  // Bit positions inside one 3-bit lamp vector
  localparam int RED    = 2;
  localparam int YELLOW = 1;
  localparam int GREEN  = 0;

  localparam logic [2:0] L_RED = 3'(1 << RED);
  localparam logic [2:0] L_YEL = 3'(1 << YELLOW);
  localparam logic [2:0] L_GRN = 3'(1 << GREEN);

  // Lamp bus layout is {T1, T2, S1, S2}, T1 in the top three bits
  localparam logic [11:0] PAT_P1 = {L_GRN, L_GRN, L_RED, L_YEL};
  localparam logic [11:0] PAT_P2 = {L_GRN, L_RED, L_YEL, L_GRN};
  localparam logic [11:0] PAT_P3 = {L_RED, L_GRN, L_GRN, L_YEL};
  localparam logic [11:0] PAT_P4 = {L_YEL, L_RED, L_GRN, L_GRN};
  localparam logic [11:0] DARK   = 12'h000;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_SEQ     = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_LONG    = 3'd4;

  localparam int DEF_DWELL_P1  = 8;
  localparam int DEF_DWELL_P2  = 6;
  localparam int DEF_DWELL_P3  = 3;
  localparam int DEF_DWELL_P4  = 4;
  localparam int DEF_DWELL_TOL = 0;

  // Legal successor in the ring P1->P2->P3->P4->P1 (2-bit wrap does P4->P1)
  function automatic phase_e next_phase(phase_e p);
    return phase_e'(2'(p) + 2'd1);
  endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// traffic_lamp_decoder: combinational decode of the 12-bit lamp bus.
// Ports:
//   lamps   in  12  {T1,T2,S1,S2}, each bit2=red bit1=yellow bit0=green
//   phase   out  2  matched phase (P1 when nothing matches)
//   legal   out  1  bus equals one of the four phase patterns
//   dark    out  1  all lamps off
//   illegal out  1  neither legal nor dark
import traffic_pkg::*;

module traffic_lamp_decoder (
  input  logic [11:0] lamps,
  output phase_e      phase,
  output logic        legal,
  output logic        dark,
  output logic        illegal
);

  // Exact pattern match; every phase pattern is one-hot per lamp vector, so
  // any non-one-hot vector falls through to the default and is illegal.
  always_comb begin
    phase = P1;
    legal = 1'b1;
    case (lamps)
      PAT_P1:  phase = P1;
      PAT_P2:  phase = P2;
      PAT_P3:  phase = P3;
      PAT_P4:  phase = P4;
      default: legal = 1'b0;
    endcase
  end

  assign dark    = (lamps == DARK);
  assign illegal = !legal && !dark;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: receive-side safety checker for the intersection
// controller. Registers the four lamp vectors, decodes them into phases and
// checks pattern legality, phase order and dwell time; the first violation
// latches a sticky fault and code until fault_clr or rst.
// Ports:
//   clk, rst (sync, active high)
//   T1, T2, S1, S2  in   3  lamp vectors (bit2 red, bit1 yellow, bit0 green)
//   fault_clr       in   1  clears FAULT, returns to SYNC
//   phase           out  2  last decoded legal phase
//   phase_valid     out  1  registered lamps decode to a legal phase
//   in_sync         out  1  monitor is in TRACK
//   fault           out  1  sticky fault
//   fault_code      out  3  1 illegal, 2 sequence, 3 dwell short, 4 dwell long
//   cycle_cnt       out 16  completed P4->P1 cycles (wrapping)
// Build option: define TRAFFIC_LAMP_MON_CYCLE_CNT_EN to build the cycle
// counter; otherwise cycle_cnt is tied to zero.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int DWELL_P1  = DEF_DWELL_P1,
  parameter int DWELL_P2  = DEF_DWELL_P2,
  parameter int DWELL_P3  = DEF_DWELL_P3,
  parameter int DWELL_P4  = DEF_DWELL_P4,
  parameter int DWELL_TOL = DEF_DWELL_TOL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  T1,
  input  logic [2:0]  T2,
  input  logic [2:0]  S1,
  input  logic [2:0]  S2,
  input  logic        fault_clr,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        in_sync,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] cycle_cnt
);

  // The dwell counter is 5 bits and must be able to reach DWELL_x+TOL+1.
  if (DWELL_P1 + DWELL_TOL > 30 || DWELL_P2 + DWELL_TOL > 30 ||
      DWELL_P3 + DWELL_TOL > 30 || DWELL_P4 + DWELL_TOL > 30 ||
      DWELL_TOL >= DWELL_P1 || DWELL_TOL >= DWELL_P2 ||
      DWELL_TOL >= DWELL_P3 || DWELL_TOL >= DWELL_P4) begin : g_param_err
    $error("traffic_lamp_monitor: dwell parameters out of range");
  end

  logic [11:0] lamp_q;
  phase_e      cur_ph;
  logic        cur_legal, cur_dark, cur_illegal;
  mon_state_e  state;
  phase_e      phase_q;     // last legal phase seen, also the tracked phase
  logic        have_ph;     // phase_q holds a real observation
  logic [4:0]  dwell_cnt, dwell_inc, dwell_lo, dwell_hi;
  phase_e      succ;
  logic [2:0]  trk_code;

  traffic_lamp_decoder u_dec (
    .lamps   (lamp_q),
    .phase   (cur_ph),
    .legal   (cur_legal),
    .dark    (cur_dark),
    .illegal (cur_illegal)
  );

  function automatic int dwell_of(phase_e p);
    case (p)
      P1:      return DWELL_P1;
      P2:      return DWELL_P2;
      P3:      return DWELL_P3;
      default: return DWELL_P4;
    endcase
  endfunction

  // TRACK checks, written in code-priority order 1 > 2 > 3 > 4
  always_comb begin
    succ      = next_phase(phase_q);
    dwell_inc = (dwell_cnt == 5'd31) ? dwell_cnt : dwell_cnt + 5'd1;
    dwell_lo  = 5'(dwell_of(phase_q) - DWELL_TOL);
    dwell_hi  = 5'(dwell_of(phase_q) + DWELL_TOL + 1);
    trk_code  = FC_NONE;
    if (cur_dark || cur_illegal)
      trk_code = FC_ILLEGAL;
    else if (cur_ph != phase_q) begin
      if (cur_ph != succ)
        trk_code = FC_SEQ;
      else if (dwell_cnt < dwell_lo)
        trk_code = FC_SHORT;
    end else if (dwell_inc == dwell_hi)
      trk_code = FC_LONG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q      <= DARK;
      state       <= ST_SYNC;
      phase_q     <= P1;
      have_ph     <= 1'b0;
      phase_valid <= 1'b0;
      in_sync     <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      dwell_cnt   <= '0;
    end else begin
      lamp_q      <= {T1, T2, S1, S2};
      phase_valid <= cur_legal;
      // phase output follows every legal decode, independent of FSM state
      if (cur_legal) begin
        phase_q <= cur_ph;
        have_ph <= 1'b1;
      end
      case (state)
        ST_SYNC: begin
          // fault_clr arriving with a new fault cancels it
          if (cur_illegal && !fault_clr) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_ILLEGAL;
          end else if (cur_legal && have_ph && cur_ph == succ) begin
            state     <= ST_TRACK;
            in_sync   <= 1'b1;
            dwell_cnt <= 5'd1;
          end
        end
        ST_TRACK: begin
          if (trk_code != FC_NONE) begin
            in_sync <= 1'b0;
            if (fault_clr)
              state <= ST_SYNC;
            else begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= trk_code;
            end
          end else if (cur_ph != phase_q)
            dwell_cnt <= 5'd1;
          else
            dwell_cnt <= dwell_inc;
        end
        default: begin
          if (fault_clr) begin
            state      <= ST_SYNC;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
      endcase
    end
  end

`ifdef TRAFFIC_LAMP_MON_CYCLE_CNT_EN
  logic        cnt_inc;
  logic [15:0] cnt_q;

  // Accepted P4->P1 change while tracking; SYNC acquisition does not count
  assign cnt_inc = (state == ST_TRACK) && (trk_code == FC_NONE) &&
                   (cur_ph != phase_q) && (phase_q == P4);

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_inc)
      cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

  assign phase = phase_q;

endmodule
